// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encodings and port indices.
package mem_arbiter_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes (CPU port 0, loader port 1) and the shared memory bus.
interface mem_arbiter_if #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DAWIDTH    = 10
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [DAWIDTH-1:0]    addr0, addr1;
  logic [WIDTH_DATA-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [WIDTH_DATA-1:0] rdata0, rdata1;
  logic                  mem_re, mem_we;
  logic [DAWIDTH-1:0]    mem_addr;
  logic [WIDTH_DATA-1:0] mem_wdata;
  logic [WIDTH_DATA-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_rr2.sv
// Two-requester winner select: round-robin on last grant, or fixed port-0 priority
// when ARB_FIXED_PRIO_EN is defined.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifndef ARB_FIXED_PRIO_EN
  input  logic last_gnt,
`endif
  output logic win_c,
  output logic any_c
);

  always_comb begin
    any_c = req0 | req1;
    win_c = PORT0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      win_c = PORT0;
`else
      win_c = (last_gnt == PORT0) ? PORT1 : PORT0;
`endif
    end else if (req1) begin
      win_c = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE -> ISSUE -> (WAIT -> RESP) -> IDLE, all outputs registered.
// Define ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DAWIDTH    = 10
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic                  port_q, port_d;
  logic                  cmd_we_q, cmd_we_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [WIDTH_DATA-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [DAWIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH_DATA-1:0] mem_wdata_q, mem_wdata_d;
  logic                  win_c, any_c;
`ifndef ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  arb_rr2 u_arb (
    .req0     (bus.req0),
    .req1     (bus.req1),
`ifndef ARB_FIXED_PRIO_EN
    .last_gnt (last_q),
`endif
    .win_c    (win_c),
    .any_c    (any_c)
  );

  // Outputs are computed one state ahead so they are valid for the whole target cycle
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    cmd_we_d    = cmd_we_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d     = ST_ISSUE;
          port_d      = win_c;
          cmd_we_d    = (win_c == PORT1) ? bus.we1    : bus.we0;
          mem_addr_d  = (win_c == PORT1) ? bus.addr1  : bus.addr0;
          mem_wdata_d = (win_c == PORT1) ? bus.wdata1 : bus.wdata0;
          mem_we_d    = cmd_we_d;
          mem_re_d    = ~cmd_we_d;
          gnt0_d      = (win_c == PORT0);
          gnt1_d      = (win_c == PORT1);
        end
      end
      ST_ISSUE: begin
        state_d = cmd_we_q ? ST_IDLE : ST_WAIT;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = port_q;
`endif
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        if (port_q == PORT1) begin
          rdata1_d  = bus.mem_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.mem_rdata;
          rvalid0_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT0;
      cmd_we_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q      <= PORT1;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      cmd_we_q    <= cmd_we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH_DATA, 32, data word width
- DAWIDTH, 10, data-memory word address width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0/req1  in  1  access request from port 0 (CPU) / port 1 (loader)
- we0/we1  in  1  1 = write, 0 = read
- addr0/addr1  in  DAWIDTH  word address
- wdata0/wdata1  in  WIDTH_DATA  write data
- gnt0/gnt1  out  1  one-cycle grant pulse
- rvalid0/rvalid1  out  1  one-cycle read-data-valid pulse
- rdata0/rdata1  out  WIDTH_DATA  read data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  DAWIDTH  memory address
- mem_wdata  out  WIDTH_DATA  memory write data
- mem_rdata  in  WIDTH_DATA  memory read data, valid one cycle after mem_re

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, encoded in 2 bits.
REQ-004 IDLE: if req0 or req1 is high, the arbiter SHALL select a winner, register its we/addr/wdata and enter ISSUE on the next edge; otherwise it SHALL stay in IDLE.
REQ-005 Round-robin: on a simultaneous request, the port not granted last SHALL win; a single requester SHALL always win.
REQ-006 ISSUE (one cycle): gnt of the winner SHALL be high; mem_re or mem_we SHALL be high per the registered we; mem_addr/mem_wdata SHALL carry the registered command.
REQ-007 After a write ISSUE, the next state SHALL be IDLE, giving 2 cycles per write.
REQ-008 After a read ISSUE, the next state SHALL be WAIT; in WAIT, mem_rdata SHALL be captured into the winner's rdata register.
REQ-009 RESP (one cycle): rvalid of the winner SHALL be high, then IDLE; 4 cycles per read. Request sampled in cycle N gives rvalid in cycle N+3.
REQ-010 rdata0/rdata1 SHALL hold their last captured value until the next read completes on that port.
REQ-011 mem_re/mem_we SHALL be low in all states except ISSUE and SHALL never be high together.
REQ-012 Requesters SHALL hold req/we/addr/wdata stable until gnt; arbitration SHALL sample inputs only in IDLE; a req dropped before IDLE sampling SHALL be ignored.
REQ-013 A requester deasserting req in the gnt cycle SHALL NOT cancel its accepted transaction.
REQ-014 The last-granted register SHALL update in the ISSUE cycle.

Reset
REQ-015 On reset assertion, state SHALL be IDLE and every output SHALL be 0 (gnt*, rvalid*, rdata*, mem_*) immediately, asynchronously.
REQ-016 Reset SHALL set last-granted to port 1 so port 0 wins the first contended arbitration.
REQ-017 Reset mid-transaction SHALL abort it; no gnt/rvalid SHALL follow for the aborted request after release.

Configuration
REQ-018 When macro ARB_FIXED_PRIO_EN is defined, port 0 SHALL always win simultaneous requests and the last-granted register SHALL be omitted; when undefined, round-robin per REQ-005 SHALL apply.

Structure
REQ-019 A shared package SHALL hold the FSM state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and port-index constants.
REQ-020 The winner-select logic SHALL be a sub-module named arb_rr2, so fixed/round-robin policy is isolated; the FSM stays in mem_arbiter.

Verification
REQ-021 Bench SHALL cover:
- reset, then req0 write addr=0x005 wdata=0xDEADBEEF -> gnt0 and mem_we with mem_addr=0x005 one cycle later; IDLE after 2 cycles.
- req1 read addr=0x005, memory model returns 0xDEADBEEF -> rvalid1 3 cycles after sampling, rdata1=0xDEADBEEF, rdata0 unchanged.
- req0 and req1 held high continuously -> grants alternate 0,1,0,1 (with ARB_FIXED_PRIO_EN: all gnt0).
- both request after reset -> first grant to port 0.
- reset asserted during WAIT of a port-0 read -> all outputs 0 at once; no rvalid0 after release.
- every cycle -> mem_re and mem_we never both 1, and at most one of gnt0/gnt1 high.
